// File: rtl/ppm16_burst_demod_if.sv
// Sample-stream and decoded-nibble signals of the 16-PPM burst demodulator.
// The bench drives through the master modport; the demodulator uses the slave modport.
interface ppm16_burst_demod_if #(
   parameter int CHIP_BITS = 2
);
   logic                 din;
   logic                 rx_start;
   logic [CHIP_BITS-1:0] corr_threshold_ext;
   logic                 packet_detected;
   logic                 dout_valid;
   logic [3:0]           dout;

   modport master (
      output din, rx_start, corr_threshold_ext,
      input  packet_detected, dout_valid, dout
   );

   modport slave (
      input  din, rx_start, corr_threshold_ext,
      output packet_detected, dout_valid, dout
   );
endinterface

// File: rtl/ppm16_burst_demod.sv
// Serial 16-PPM burst demodulator: sync hunt, header/length parse, data nibble stream.
// Optional debug outputs are enabled by defining PPM16_DEMOD_DEBUG_EN.
module ppm16_burst_demod #(
   parameter int CHIP_BITS    = 2,
   parameter int HDR1_SYMBOLS = 4,
   parameter int HDR2_SYMBOLS = 2
) (
   input  logic clk,
   input  logic resetn,
   ppm16_burst_demod_if.slave bus
`ifdef PPM16_DEMOD_DEBUG_EN
   ,
   output logic [2:0]             dbg_state,
   output logic [16*CHIP_BITS-1:0] dbg_shifted_bits,
   output logic [CHIP_BITS:0]     dbg_corr_peak,
   output logic [3:0]             dbg_corr_symbol,
   output logic                   dbg_threshold_unmet,
   output logic [3:0]             dbg_symbol_chip_count,
   output logic [7:0]             dbg_data_symbol_count,
   output logic [7:0]             dbg_packet_len
`endif
);
   localparam int W    = 16 * CHIP_BITS;
   localparam int CW   = CHIP_BITS + 1;
   localparam int CB_W = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEARCH = 3'd1,
      HDR1   = 3'd2,
      HDR2   = 3'd3,
      DATA   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         sr_q, sr_d;
   logic [CHIP_BITS-1:0] thr_q, thr_d;
   logic [CB_W-1:0]      bit_q, bit_d;
   logic [3:0]           chip_q, chip_d;
   logic [7:0]           sym_cnt_q, sym_cnt_d;
   logic [7:0]           len_q, len_d;
   logic                 pkt_q, pkt_d;
   logic                 vld_q, vld_d;
   logic [3:0]           dout_q, dout_d;

   logic [CW-1:0]        cnt [16];
   logic [CW-1:0]        peak;
   logic [3:0]           symbol;
   logic [CW-1:0]        thr_eff;
   logic                 sync_hit;
   logic                 bit_last;
   logic                 sym_done;

   function automatic logic [CW-1:0] popcnt(input logic [CHIP_BITS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < CHIP_BITS; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   // Correlator: descending scan with >= leaves the lowest chip among equal peaks
   always_comb begin
      peak   = '0;
      symbol = '0;
      for (int c = 0; c < 16; c++) cnt[c] = popcnt(sr_q[c*CHIP_BITS +: CHIP_BITS]);
      for (int c = 15; c >= 0; c--) begin
         if (cnt[c] >= peak) begin
            peak   = cnt[c];
            symbol = 4'(c);
         end
      end
   end

   assign thr_eff  = (thr_q == '0) ? CW'(1) : {1'b0, thr_q};
   assign sync_hit = (sr_q[W-1:CHIP_BITS] == '0) && (cnt[0] >= thr_eff);
   assign bit_last = (bit_q == CB_W'(CHIP_BITS - 1));
   assign sym_done = bit_last && (chip_q == 4'd15);

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      thr_d     = thr_q;
      bit_d     = bit_q;
      chip_d    = chip_q;
      sym_cnt_d = sym_cnt_q;
      len_d     = len_q;
      pkt_d     = pkt_q;
      vld_d     = 1'b0;
      dout_d    = dout_q;

      if (state_q != IDLE) sr_d = {bus.din, sr_q[W-1:1]};

      if (state_q == HDR1 || state_q == HDR2 || state_q == DATA) begin
         if (bit_last) begin
            bit_d  = '0;
            chip_d = chip_q + 4'd1;
         end else begin
            bit_d = bit_q + CB_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.rx_start) begin
               thr_d   = bus.corr_threshold_ext;
               sr_d    = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (sync_hit) begin
               pkt_d     = 1'b1;
               bit_d     = '0;
               chip_d    = '0;
               sym_cnt_d = '0;
               state_d   = HDR1;
            end
         end
         HDR1: begin
            if (sym_done) begin
               if (sym_cnt_q == 8'(HDR1_SYMBOLS - 1)) begin
                  sym_cnt_d = '0;
                  state_d   = HDR2;
               end else begin
                  sym_cnt_d = sym_cnt_q + 8'd1;
               end
            end
         end
         HDR2: begin
            if (sym_done) begin
               if (sym_cnt_q == 8'(HDR2_SYMBOLS - 1)) begin
                  len_d     = {len_q[7:4], symbol};
                  sym_cnt_d = '0;
                  if ({len_q[7:4], symbol} == 8'd0) begin
                     pkt_d   = 1'b0;
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  len_d[7:4] = symbol;
                  sym_cnt_d  = sym_cnt_q + 8'd1;
               end
            end
         end
         DATA: begin
            if (sym_done) begin
               vld_d  = 1'b1;
               dout_d = symbol;
               if (sym_cnt_q == len_q - 8'd1) begin
                  sym_cnt_d = '0;
                  pkt_d     = 1'b0;
                  state_d   = IDLE;
               end else begin
                  sym_cnt_d = sym_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         thr_q     <= '0;
         bit_q     <= '0;
         chip_q    <= '0;
         sym_cnt_q <= '0;
         len_q     <= '0;
         pkt_q     <= 1'b0;
         vld_q     <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         thr_q     <= thr_d;
         bit_q     <= bit_d;
         chip_q    <= chip_d;
         sym_cnt_q <= sym_cnt_d;
         len_q     <= len_d;
         pkt_q     <= pkt_d;
         vld_q     <= vld_d;
         dout_q    <= dout_d;
      end
   end

   assign bus.packet_detected = pkt_q;
   assign bus.dout_valid      = vld_q;
   assign bus.dout            = dout_q;

`ifdef PPM16_DEMOD_DEBUG_EN
   assign dbg_state             = state_q;
   assign dbg_shifted_bits      = sr_q;
   assign dbg_corr_peak         = peak;
   assign dbg_corr_symbol       = symbol;
   assign dbg_threshold_unmet   = (peak < {1'b0, thr_q});
   assign dbg_symbol_chip_count = chip_q;
   assign dbg_data_symbol_count = sym_cnt_q;
   assign dbg_packet_len        = len_q;
`endif
endmodule

// File: tb/tb_ppm16_burst_demod.sv
// Directed bench for ppm16_burst_demod (CHIP_BITS=2): packets, noise, zero length,
// ties, mid-packet reset and rx_start while busy.
module tb_ppm16_burst_demod;
   localparam int CB = 2;

   logic clk = 1'b0;
   logic resetn;

   ppm16_burst_demod_if #(.CHIP_BITS(CB)) bus();

`ifdef PPM16_DEMOD_DEBUG_EN
   logic [2:0]  dbg_state;
   logic [31:0] dbg_shifted_bits;
   logic [2:0]  dbg_corr_peak;
   logic [3:0]  dbg_corr_symbol;
   logic        dbg_threshold_unmet;
   logic [3:0]  dbg_symbol_chip_count;
   logic [7:0]  dbg_data_symbol_count;
   logic [7:0]  dbg_packet_len;
`endif

   ppm16_burst_demod #(.CHIP_BITS(CB), .HDR1_SYMBOLS(4), .HDR2_SYMBOLS(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
`ifdef PPM16_DEMOD_DEBUG_EN
      ,
      .dbg_state             (dbg_state),
      .dbg_shifted_bits      (dbg_shifted_bits),
      .dbg_corr_peak         (dbg_corr_peak),
      .dbg_corr_symbol       (dbg_corr_symbol),
      .dbg_threshold_unmet   (dbg_threshold_unmet),
      .dbg_symbol_chip_count (dbg_symbol_chip_count),
      .dbg_data_symbol_count (dbg_data_symbol_count),
      .dbg_packet_len        (dbg_packet_len)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log and packet_detected edge history, sampled on the falling edge
   int         v_cyc[$];
   logic [3:0] v_val[$];
   int         pd_rise_cnt = 0;
   int         pd_rise_cyc = 0;
   int         pd_fall_cyc = 0;
   logic       pd_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.dout_valid === 1'b1) begin
         v_cyc.push_back(cyc);
         v_val.push_back(bus.dout);
      end
      if (bus.packet_detected === 1'b1 && !pd_prev) begin
         pd_rise_cnt <= pd_rise_cnt + 1;
         pd_rise_cyc <= cyc;
      end
      if (bus.packet_detected === 1'b0 && pd_prev) pd_fall_cyc <= cyc;
      pd_prev <= (bus.packet_detected === 1'b1);
   end

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] sym_word(input int v);
      logic [31:0] w;
      w = 32'd3;
      return w << (2 * v);
   endfunction

   task automatic drive_bit(input logic b);
      bus.din = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b0);
   endtask

   task automatic send_range(input logic [31:0] w, input int lo, input int hi, input int pulse);
      for (int i = lo; i <= hi; i++) begin
         bus.rx_start = (i == pulse);
         drive_bit(w[i]);
      end
      bus.rx_start = 1'b0;
   endtask

   task automatic send_sym(input int v);
      send_range(sym_word(v), 0, 31, -1);
   endtask

   task automatic arm(input logic [1:0] thr);
      bus.corr_threshold_ext = thr;
      bus.rx_start = 1'b1;
      drive_bit(1'b0);
      bus.rx_start = 1'b0;
      bus.corr_threshold_ext = 2'b00;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b0);
      resetn = 1'b1;
   endtask

   task automatic send_hdr1();
      send_sym(1); send_sym(2); send_sym(3); send_sym(4);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (bus.packet_detected !== 1'b0) begin
         n_fail++; $display("FAIL reset_pd got=%b want=0", bus.packet_detected);
      end
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_vld got=%b want=0", bus.dout_valid);
      end
      n_tests++;
      if (bus.dout !== 4'h0) begin
         n_fail++; $display("FAIL reset_dout got=%h want=0", bus.dout);
      end
   endtask

   task automatic test_basic();
      int b, r, s_end;
      logic [3:0] exp_v [3];
      exp_v[0] = 4'h5; exp_v[1] = 4'hA; exp_v[2] = 4'hF;
      b = v_val.size(); r = pd_rise_cnt;
      arm(2'b10);
      send_sym(0); s_end = cyc;
      send_hdr1();
      send_sym(0); send_sym(3);
      send_sym(5); send_sym(10); send_sym(15);
      idle(6);
      n_tests++;
      if (pd_rise_cnt !== r + 1 || pd_rise_cyc !== s_end + 1) begin
         n_fail++; $display("FAIL basic_pd_rise got=%0d want=%0d", pd_rise_cyc - s_end, 1);
      end
      n_tests++;
      if (v_val.size() !== b + 3) begin
         n_fail++; $display("FAIL basic_strobe_count got=%0d want=3", v_val.size() - b);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (v_val[b+i] !== exp_v[i]) begin
               n_fail++; $display("FAIL basic_dout[%0d] got=%h want=%h", i, v_val[b+i], exp_v[i]);
            end
            n_tests++;
            if (v_cyc[b+i] !== s_end + 225 + 32 * i) begin
               n_fail++; $display("FAIL basic_strobe_cyc[%0d] got=%0d want=%0d", i, v_cyc[b+i] - s_end, 225 + 32 * i);
            end
         end
      end
      n_tests++;
      if (pd_fall_cyc !== s_end + 289) begin
         n_fail++; $display("FAIL basic_pd_fall got=%0d want=%0d", pd_fall_cyc - s_end, 289);
      end
      n_tests++;
      if (bus.dout !== 4'hF || bus.dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_dout_hold got=%h/%b want=f/0", bus.dout, bus.dout_valid);
      end
   endtask

   task automatic test_noise();
      int b, r;
      b = v_val.size(); r = pd_rise_cnt;
      arm(2'b10);
      for (int i = 0; i < 240; i++) drive_bit((i % 40) == 5);
      n_tests++;
      if (pd_rise_cnt !== r || bus.packet_detected !== 1'b0) begin
         n_fail++; $display("FAIL noise_detect got=%0d rises want=0", pd_rise_cnt - r);
      end
      n_tests++;
      if (v_val.size() !== b) begin
         n_fail++; $display("FAIL noise_strobes got=%0d want=0", v_val.size() - b);
      end
      do_reset();
   endtask

   task automatic test_zero_len();
      int b, r, h_end;
      b = v_val.size(); r = pd_rise_cnt;
      arm(2'b10);
      send_sym(0); send_hdr1(); send_sym(0); send_sym(0); h_end = cyc;
      idle(4);
      n_tests++;
      if (pd_rise_cnt !== r + 1 || pd_fall_cyc !== h_end + 1) begin
         n_fail++; $display("FAIL zlen_pd got=%0d/%0d want=1/1", pd_rise_cnt - r, pd_fall_cyc - h_end);
      end
      n_tests++;
      if (v_val.size() !== b) begin
         n_fail++; $display("FAIL zlen_strobes got=%0d want=0", v_val.size() - b);
      end
      send_sym(0); send_hdr1(); send_sym(0); send_sym(1); send_sym(6);
      idle(4);
      n_tests++;
      if (pd_rise_cnt !== r + 1 || v_val.size() !== b) begin
         n_fail++; $display("FAIL unarmed_ignored got=%0d rises/%0d strobes want=0/0", pd_rise_cnt - r - 1, v_val.size() - b);
      end
      arm(2'b10);
      send_sym(0); send_hdr1(); send_sym(0); send_sym(2); send_sym(9); send_sym(12);
      idle(4);
      n_tests++;
      if (v_val.size() !== b + 2) begin
         n_fail++; $display("FAIL rearm_count got=%0d want=2", v_val.size() - b);
      end else begin
         n_tests++;
         if (v_val[b] !== 4'h9 || v_val[b+1] !== 4'hC) begin
            n_fail++; $display("FAIL rearm_dout got=%h,%h want=9,c", v_val[b], v_val[b+1]);
         end
      end
   endtask

   task automatic test_tie_weak();
      int b;
      logic [31:0] tie;
      tie = sym_word(3) | sym_word(9);
      b = v_val.size();
      arm(2'b10);
      send_sym(0); send_hdr1(); send_sym(0); send_sym(2);
      send_range(tie, 0, 31, -1);
      send_range(32'd0, 0, 31, -1);
      idle(4);
      n_tests++;
      if (v_val.size() !== b + 2) begin
         n_fail++; $display("FAIL tie_count got=%0d want=2", v_val.size() - b);
      end else begin
         n_tests++;
         if (v_val[b] !== 4'h3) begin
            n_fail++; $display("FAIL tie_dout got=%h want=3", v_val[b]);
         end
         n_tests++;
         if (v_val[b+1] !== 4'h0) begin
            n_fail++; $display("FAIL weak_dout got=%h want=0", v_val[b+1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int b, r;
      b = v_val.size(); r = pd_rise_cnt;
      arm(2'b10);
      send_sym(0); send_hdr1(); send_sym(0); send_sym(3);
      send_sym(7);
      send_range(sym_word(2), 0, 9, -1);
      n_tests++;
      if (bus.packet_detected !== 1'b1 || bus.dout !== 4'h7) begin
         n_fail++; $display("FAIL mid_pre_reset got=%b/%h want=1/7", bus.packet_detected, bus.dout);
      end
      resetn = 1'b0;
      drive_bit(1'b0);
      resetn = 1'b1;
      n_tests++;
      if (bus.packet_detected !== 1'b0 || bus.dout_valid !== 1'b0 || bus.dout !== 4'h0) begin
         n_fail++; $display("FAIL mid_reset_outputs got=%b/%b/%h want=0/0/0", bus.packet_detected, bus.dout_valid, bus.dout);
      end
      send_range(sym_word(2), 11, 31, -1);
      send_sym(3);
      send_sym(0); send_hdr1(); send_sym(0); send_sym(1); send_sym(4);
      idle(4);
      n_tests++;
      if (v_val.size() !== b + 1 || pd_rise_cnt !== r + 1) begin
         n_fail++; $display("FAIL mid_after_reset got=%0d strobes/%0d rises want=1/1", v_val.size() - b, pd_rise_cnt - r);
      end
   endtask

   task automatic test_busy_rxstart();
      int b, s_end;
      b = v_val.size();
      arm(2'b10);
      send_sym(0); s_end = cyc;
      bus.corr_threshold_ext = 2'b01;
      send_range(sym_word(1), 0, 31, 10);
      send_sym(2); send_sym(3); send_sym(4);
      send_sym(0); send_sym(2);
      send_sym(8);
      send_range(sym_word(1), 0, 31, 20);
      bus.corr_threshold_ext = 2'b00;
      idle(4);
      n_tests++;
      if (v_val.size() !== b + 2) begin
         n_fail++; $display("FAIL busy_count got=%0d want=2", v_val.size() - b);
      end else begin
         n_tests++;
         if (v_val[b] !== 4'h8 || v_val[b+1] !== 4'h1) begin
            n_fail++; $display("FAIL busy_dout got=%h,%h want=8,1", v_val[b], v_val[b+1]);
         end
         n_tests++;
         if (v_cyc[b] !== s_end + 225 || v_cyc[b+1] !== s_end + 257) begin
            n_fail++; $display("FAIL busy_align got=%0d,%0d want=225,257", v_cyc[b] - s_end, v_cyc[b+1] - s_end);
         end
      end
      n_tests++;
      if (bus.packet_detected !== 1'b0) begin
         n_fail++; $display("FAIL busy_pd_end got=%b want=0", bus.packet_detected);
      end
   endtask

   initial begin
      resetn = 1'b0;
      bus.din = 1'b0;
      bus.rx_start = 1'b0;
      bus.corr_threshold_ext = 2'b00;
      test_reset();
      test_basic();
      test_noise();
      test_zero_len();
      test_tie_weak();
      test_reset_mid();
      test_busy_rxstart();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
